// File: rtl/clocked_event_delay_pkg.sv
// clocked_event_delay_pkg: shared defaults and the modular due compare
package clocked_event_delay_pkg;
  localparam int CH_DEF    = 4;
  localparam int CNT_W_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int TS_MAX    = 33;
  function automatic int ts_width(input int cnt_w);
    return cnt_w + 1;
  endfunction
  // due once (ts - head) lands in the non-negative half of the ts_w-bit ring
  function automatic logic is_due(input logic [TS_MAX-1:0] ts, input logic [TS_MAX-1:0] head,
                                  input int ts_w);
    logic [TS_MAX-1:0] diff;
    logic [5:0] idx;
    diff = ts - head;
    idx  = 6'(ts_w - 1);
    return ~diff[idx];
  endfunction
endpackage

// File: rtl/clocked_event_delay_ch.sv
// clocked_event_delay_ch: one channel's due-time FIFO, release toggle and overflow flag
module clocked_event_delay_ch
  import clocked_event_delay_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CNT_W:0]         ts_i,
  input  logic [CNT_W-1:0]       dly_i,
  input  logic                   ev_i,
  input  logic                   err_clr_i,
  output logic                   out_o,
  output logic                   err_o,
  output logic                   pending_o
);
  localparam int TS_W = ts_width(CNT_W);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  logic [TS_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_q, err_q, drop_q;
  logic            pop, push;
  logic [TS_W-1:0] due;
  always_comb begin
    pop  = (cnt_q != '0) && is_due(TS_MAX'(ts_i), TS_MAX'(mem_q[rd_q]), TS_W);
    push = ev_i && ((cnt_q != CW'(DEPTH)) || pop);
    due  = ts_i + TS_W'(dly_i) + TS_W'(1);
    rd_d  = rd_q + PW'(pop);
    wr_d  = wr_q + PW'(push);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      err_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      out_q  <= out_q ^ pop;
      drop_q <= ev_i & ~push;
      err_q  <= drop_q | (err_q & ~err_clr_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= due;
  end
  assign out_o     = out_q;
  assign err_o     = err_q;
  assign pending_o = cnt_d != '0;
endmodule

// File: rtl/clocked_event_delay.sv
// clocked_event_delay: delays 2-phase request events per channel by a runtime cycle count
module clocked_event_delay
  import clocked_event_delay_pkg::*;
#(
  parameter int CH    = CH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] dly_val,
  input  logic [CH-1:0]    inR,
  input  logic             err_clr,
  output logic [CH-1:0]    outR,
  output logic [CH-1:0]    err,
  output logic             busy
);
  localparam int TS_W = ts_width(CNT_W);
  logic [TS_W-1:0] ts_q;
  logic [CH-1:0]   hist_q, ev, pend;
  logic            busy_q;
  assign ev = inR ^ hist_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q   <= '0;
      hist_q <= '0;
      busy_q <= 1'b0;
    end else begin
      ts_q   <= ts_q + TS_W'(1);
      hist_q <= inR;
      busy_q <= |pend;
    end
  end
  for (genvar i = 0; i < CH; i++) begin : g_ch
    clocked_event_delay_ch #(.CNT_W(CNT_W), .DEPTH(DEPTH)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .ts_i      (ts_q),
      .dly_i     (dly_val),
      .ev_i      (ev[i]),
      .err_clr_i (err_clr),
      .out_o     (outR[i]),
      .err_o     (err[i]),
      .pending_o (pend[i])
    );
  end
  assign busy = busy_q;
endmodule

// File: doc/clocked_event_delay.md
Name: clocked_event_delay

Overview:
- Parametrised, clock-synchronous successor to the fixed LUT delay chains.
- Delays 2-phase (toggle) request events on CH independent channels by a runtime-programmable number of clock cycles.
- Each channel can hold several events in flight at once.
- Used where a bundled-data request must be matched to a datapath delay that is set at runtime rather than by a hard-wired LUT count.

Parameters:
- CH, 4, number of independent request channels.
- CNT_W, 8, width of the delay value. Maximum delay is 2^CNT_W-1 cycles.
- DEPTH, 4, outstanding events per channel (queue depth, ≥2, power of two).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset.
- dly_val  input  CNT_W  programmed delay D; sampled per event at the capturing edge.
- inR  input  CH  2-phase request inputs, synchronous to clk; each transition is one event.
- outR  output  CH  delayed 2-phase requests; one toggle per accepted event.
- err  output  CH  sticky per-channel overflow flag.
- err_clr  input  1  synchronous clear of all err bits.
- busy  output  1  high while any channel has an event pending.

Behaviour:
- Reset (rst=0, async): outR=0, err=0, busy=0, all queues empty, free-running timestamp counter=0, input history register=0.
  - Environment holds inR=0 while rst is low and at reset release.
- Event detection: channel i has an event at edge e when inR[i] differs from the history bit registered at e-1.
  - History updates every edge.
  - At most one event per channel per cycle.
- Timestamp: counter ts is CNT_W+1 bits, increments every edge, wraps freely.
- Accept: at event edge e, push due = ts(e)+D+1 (mod 2^(CNT_W+1)) into channel i's queue.
- Release: when the queue head is due, i.e. (ts - head) mod 2^(CNT_W+1) has MSB=0:
  - pop the head;
  - toggle outR[i] at that edge.
  - Nominal latency: outR[i] toggles at edge e+D+1. D=0 gives 1 cycle; D=2^CNT_W-1 gives 2^CNT_W cycles.
- Ordering: strict FIFO per channel. If D decreases between events, a later event waits behind an earlier one.
  - A blocked event releases on the edge after its predecessor.
  - Lateness is bounded by 2^CNT_W-1, so the modular compare stays valid.
- At most one release per channel per cycle.
- Full queue:
  - An event arriving with no simultaneous pop is dropped.
  - err[i] is set on the next edge; outR is unaffected.
  - Simultaneous pop and push on a full queue: the event is accepted and err stays clear.
- err_clr=1 clears all err bits at the next edge. If an overflow happens on that same edge, set wins.
- busy is registered: 1 when any queue is non-empty after the edge.
- Channels are fully independent. Events on several channels in the same cycle are all accepted.
- Reset mid-operation flushes all pending events, with no output toggles. outR returns to 0 asynchronously.

Decomposition:
- Shared package holds:
  - default widths and depth;
  - a helper function for the modular "due" compare;
  - the timestamp width constant (CNT_W+1).
- One sub-module, clocked_event_delay_ch: one channel's queue, head compare, outR toggle flop and err flag. It is instantiated CH times.
- The top holds the shared timestamp counter, input history register and busy OR-reduction.

Test Plan:
1. Basic latency: D=5, after reset toggle inR[0] 0→1 at edge 10 → outR[0] toggles 0→1 at edge 16. Other outR stay 0; busy high for edges 10–15.
2. Minimum and maximum delay (CNT_W=8):
   - D=0, inR[1] toggle at edge 20 → outR[1] toggles at edge 21.
   - D=255, toggle at edge 30 → toggle at edge 286. This case crosses a ts wrap when started near ts=500.
3. Pipelined events: D=10, inR[2] toggles at edges 40, 41, 43, 44 → outR[2] toggles at edges 51, 52, 54, 55; err[2]=0.
4. Overflow (DEPTH=4): D=20, five toggles of inR[3] at edges 60–64 → toggles out at edges 81–84 only; err[3]=1 from edge 65. err_clr at edge 90 → err[3]=0 at edge 91.
5. Decreasing D: D=10 for an event at edge 100, then D=0 for an event at edge 101 → outR toggles at edge 111, then edge 112 (order kept, second one late).
6. Reset mid-flight: D=50, events on all channels at edge 200; rst=0 at edge 220 for 2 cycles → outR=0 immediately, busy=0, no toggles in the following 60 cycles.
